// File: rtl/cordic_vectoring_iter.sv
// ---------------------------------------------------------------------------
// cordic_vectoring_iter : iterative CORDIC vectoring engine (|v|, atan2).
// Optional 1/K gain compensation via CORDIC_GAIN_COMP_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cordic_vectoring_iter #(
  parameter int N_ITER = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] mag_out,
  output logic [31:0] angle_out,
  output logic        out_valid,
  input  logic        out_ready
);

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_GAIN = 2'd2, S_DONE = 2'd3} state_t;
  localparam logic [63:0] C_INV_K = 64'h0000_0000_9B74_EDA9;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd2} state_t;
`endif

  localparam logic [4:0] C_LAST = 5'(N_ITER - 1);

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic signed [33:0] x_q, x_d, y_q, y_d;
  logic [31:0]        z_q, z_d;
  logic               zero_q, zero_d;
  logic [31:0]        mag_q, mag_d;
  logic [31:0]        ang_q, ang_d;

  logic signed [33:0] x_sh, y_sh, x_ext, y_ext;
  logic [31:0]        atan_i;

  // atan(2^-i) in binary-angle units where 2^32 is a full turn
  function automatic logic [31:0] atan_rom(input logic [4:0] i);
    case (i)
      5'd0:    atan_rom = 32'h2000_0000;
      5'd1:    atan_rom = 32'h12E4_051E;
      5'd2:    atan_rom = 32'h09FB_385B;
      5'd3:    atan_rom = 32'h0511_11D4;
      5'd4:    atan_rom = 32'h028B_0D43;
      5'd5:    atan_rom = 32'h0145_D7E1;
      5'd6:    atan_rom = 32'h00A2_F61E;
      5'd7:    atan_rom = 32'h0051_7C55;
      5'd8:    atan_rom = 32'h0028_BE53;
      5'd9:    atan_rom = 32'h0014_5F2F;
      5'd10:   atan_rom = 32'h000A_2F98;
      5'd11:   atan_rom = 32'h0005_17CC;
      5'd12:   atan_rom = 32'h0002_8BE6;
      5'd13:   atan_rom = 32'h0001_45F3;
      5'd14:   atan_rom = 32'h0000_A2FA;
      5'd15:   atan_rom = 32'h0000_517D;
      5'd16:   atan_rom = 32'h0000_28BE;
      5'd17:   atan_rom = 32'h0000_145F;
      5'd18:   atan_rom = 32'h0000_0A30;
      5'd19:   atan_rom = 32'h0000_0518;
      5'd20:   atan_rom = 32'h0000_028C;
      5'd21:   atan_rom = 32'h0000_0146;
      5'd22:   atan_rom = 32'h0000_00A3;
      5'd23:   atan_rom = 32'h0000_0051;
      default: atan_rom = 32'h0000_0000;
    endcase
  endfunction

  assign x_sh   = x_q >>> cnt_q;
  assign y_sh   = y_q >>> cnt_q;
  assign x_ext  = {{2{x_in[31]}}, x_in};
  assign y_ext  = {{2{y_in[31]}}, y_in};
  assign atan_i = atan_rom(cnt_q);

`ifdef CORDIC_GAIN_COMP_EN
  logic [63:0] prod;
  assign prod = {32'd0, x_q[31:0]} * C_INV_K;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    ang_d   = ang_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Left half-plane is folded into the right by a 180 degree pre-rotation
          if (x_in[31]) begin
            x_d = -x_ext;
            y_d = -y_ext;
            z_d = 32'h8000_0000;
          end else begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = 32'h0000_0000;
          end
          zero_d  = (x_in == 32'd0) && (y_in == 32'd0);
          cnt_d   = 5'd0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (!y_q[33]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end
        if (cnt_q == C_LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = S_GAIN;
`else
          mag_d   = zero_q ? 32'd0 : x_d[31:0];
          ang_d   = zero_q ? 32'd0 : z_d;
          state_d = S_DONE;
`endif
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_GAIN: begin
        mag_d   = zero_q ? 32'd0 : prod[63:32];
        ang_d   = zero_q ? 32'd0 : z_q;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      ang_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign mag_out   = mag_q;
  assign angle_out = ang_q;

endmodule

`default_nettype wire
